// File: rtl/pmem_arbiter.sv
// Shared physical-memory arbiter for the I-cache and D-cache line ports.
// Non-preemptive, one transaction in flight, alternating grant on contention.
module pmem_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int LINE_WIDTH = 128
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic                  i_pmem_read,
    input  logic [ADDR_WIDTH-1:0] i_pmem_address,
    output logic [LINE_WIDTH-1:0] i_pmem_rdata,
    output logic                  i_pmem_resp,

    input  logic                  d_pmem_read,
    input  logic                  d_pmem_write,
    input  logic [ADDR_WIDTH-1:0] d_pmem_address,
    input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
    output logic [LINE_WIDTH-1:0] d_pmem_rdata,
    output logic                  d_pmem_resp,

    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2,
        DRAIN   = 2'd3
    } state_e;

    typedef enum logic {
        SIDE_I = 1'b0,
        SIDE_D = 1'b1
    } side_e;

    state_e                state_q, state_d;
    side_e                 last_grant_q, last_grant_d;
    logic                  rd_q, rd_d;
    logic                  wr_q, wr_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LINE_WIDTH-1:0] wdata_q, wdata_d;

    logic i_req;
    logic d_req;
    logic busy;
    logic fwd_i;
    logic fwd_d;

    assign i_req = i_pmem_read;
    assign d_req = d_pmem_read | d_pmem_write;

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        rd_d         = rd_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        fwd_i        = 1'b0;
        fwd_d        = 1'b0;

        case (state_q)
            IDLE: begin
                // On contention the side that did not win last time is served.
                if (i_req && (!d_req || last_grant_q == SIDE_D)) begin
                    state_d      = GRANT_I;
                    last_grant_d = SIDE_I;
                    rd_d         = 1'b1;
                    wr_d         = 1'b0;
                    addr_d       = i_pmem_address;
                    wdata_d      = '0;
                end else if (d_req) begin
                    state_d      = GRANT_D;
                    last_grant_d = SIDE_D;
                    rd_d         = d_pmem_read;
                    wr_d         = d_pmem_write;
                    addr_d       = d_pmem_address;
                    wdata_d      = d_pmem_wdata;
                end
            end

            GRANT_I: begin
                if (pmem_resp) begin
                    fwd_i   = i_req;
                    state_d = IDLE;
                end else if (!i_req) begin
                    state_d = DRAIN;
                end
            end

            GRANT_D: begin
                if (pmem_resp) begin
                    fwd_d   = d_req;
                    state_d = IDLE;
                end else if (!d_req) begin
                    state_d = DRAIN;
                end
            end

            // Memory cannot abort: hold the latched command until it completes.
            DRAIN: begin
                if (pmem_resp) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: the line-wide data register is reset too, so pmem_wdata is defined from reset onward.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= SIDE_I;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            // NOTE: non-blocking assignments so all registers update from the same pre-edge values.
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
        end
    end

    assign busy = (state_q != IDLE);

    assign pmem_read    = busy & rd_q;
    assign pmem_write   = busy & wr_q;
    assign pmem_address = busy ? addr_q  : '0;
    assign pmem_wdata   = busy ? wdata_q : '0;

    assign i_pmem_resp  = fwd_i;
    assign i_pmem_rdata = fwd_i ? pmem_rdata : '0;
    assign d_pmem_resp  = fwd_d;
    assign d_pmem_rdata = fwd_d ? pmem_rdata : '0;

endmodule
